serv_vpu_resp: RTL and testbench

VPU-side responder for the SERV core's vector handshake. Captures bit-serial rs1/rs2 operands during the core's stage one. Accepts the core's level-held VPU valid strobe, executes vset* configuration or times a vector arithmetic op, and returns a one-cycle ready pulse. For config ops it also streams the resulting vl back bit-serially during stage two.

---
 rtl/serv_vpu_resp.sv | 197 +++++++++++++++++++
 tb/tb_serv_vpu_resp.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/serv_vpu_resp.sv
// VPU responder for SERV: bit-serial operand capture, vset* execution, timed arithmetic ops.
// Latency: config ops raise ready 2 cycles after valid; arithmetic ops after max(vl,1)+1 cycles.
// Backpressure: none; the core holds valid as a level, and WAIT ignores it until stage two is done.
// Optional feature: SERV_VPU_VSETVL_EN adds the rs2 operand register and the vsetvl register form.
module serv_vpu_resp #(
  parameter int VLEN = 128,
  parameter int VLW  = $clog2(VLEN) + 1
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_cnt_en,
  input  logic           i_init,
  input  logic           i_rs1,
  input  logic           i_rs2,
  input  logic           i_vpu_valid,
  input  logic           i_config_op,
  input  logic           i_vset_reg,
  input  logic [10:0]    i_zimm,
  input  logic           i_rs1_zero,
  input  logic           i_rd_zero,
  output logic           o_vpu_ready,
  output logic           o_rd,
  output logic           o_busy,
  output logic [VLW-1:0] o_vl,
  output logic           o_vill,
  output logic [2:0]     o_vsew,
  output logic [2:0]     o_vlmul
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_RESP,
    S_WAIT,
    S_OUT
  } state_t;

  state_t         state_q, state_d;
  logic           config_q, config_d;
  logic [VLW-1:0] cnt_q, cnt_d;
  logic [VLW-1:0] vl_q, vl_d;
  logic           vill_q, vill_d;
  logic [2:0]     vsew_q, vsew_d;
  logic [2:0]     vlmul_q, vlmul_d;
  logic [31:0]    result_q, result_d;
  logic [31:0]    rs1_q;

  logic [10:0]    vt;
  logic [2:0]     vt_vsew;
  logic [2:0]     vt_vlmul;
  logic           cfg_vill;
  logic [31:0]    vlmax;
  logic [31:0]    avl_vl;
  logic [31:0]    cfg_vl;
  logic           unused_ok;

`ifdef SERV_VPU_VSETVL_EN
  logic [31:0]    rs2_q;

  // Shift in the rs2 operand LSB first while the core is in its operand phase.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rs2_q <= '0;
    end else if (i_cnt_en && i_init) begin
      rs2_q <= {i_rs2, rs2_q[31:1]};
    end
  end

  assign vt        = i_vset_reg ? rs2_q[10:0] : i_zimm;
  assign cfg_vill  = (vt[5:3] > 3'd2) || (vt[2:0] > 3'd3) || (vt[10:8] != 3'b000)
                     || (i_vset_reg && (rs2_q[31:11] != 21'd0));
  assign unused_ok = ^{vt[7:6]};
`else
  assign vt        = i_zimm;
  assign cfg_vill  = (vt[5:3] > 3'd2) || (vt[2:0] > 3'd3) || (vt[10:8] != 3'b000);
  assign unused_ok = ^{vt[7:6], i_rs2, i_vset_reg};
`endif

  // Shift in the rs1 operand (AVL) LSB first; also runs outside IDLE if the core re-enters stage one.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rs1_q <= '0;
    end else if (i_cnt_en && i_init) begin
      rs1_q <= {i_rs1, rs1_q[31:1]};
    end
  end

  // vtype decode and vl selection; only consumed when the vtype is legal, so out-of-range shifts are harmless.
  always_comb begin
    vt_vsew  = vt[5:3];
    vt_vlmul = vt[2:0];
    vlmax    = (32'(VLEN) >> ({1'b0, vt_vsew} + 4'd3)) << vt_vlmul;
    avl_vl   = (rs1_q < vlmax) ? rs1_q : vlmax;
    if (!i_rs1_zero) begin
      cfg_vl = avl_vl;
    end else if (!i_rd_zero) begin
      cfg_vl = vlmax;
    end else begin
      cfg_vl = 32'(vl_q);
    end
  end

  // State and architectural registers; reset leaves vtype illegal and vl zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      config_q <= 1'b0;
      cnt_q    <= '0;
      vl_q     <= '0;
      vill_q   <= 1'b1;
      vsew_q   <= 3'd0;
      vlmul_q  <= 3'd0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      config_q <= config_d;
      cnt_q    <= cnt_d;
      vl_q     <= vl_d;
      vill_q   <= vill_d;
      vsew_q   <= vsew_d;
      vlmul_q  <= vlmul_d;
      result_q <= result_d;
    end
  end

  // Next-state logic: accept, execute, pulse ready, then stream the result during stage two.
  always_comb begin
    state_d  = state_q;
    config_d = config_q;
    cnt_d    = cnt_q;
    vl_d     = vl_q;
    vill_d   = vill_q;
    vsew_d   = vsew_q;
    vlmul_d  = vlmul_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (i_vpu_valid) begin
          state_d  = S_EXEC;
          config_d = i_config_op;
          cnt_d    = vl_q;
        end
      end
      S_EXEC: begin
        if (config_q) begin
          state_d = S_RESP;
          if (cfg_vill) begin
            vl_d    = '0;
            vill_d  = 1'b1;
            vsew_d  = 3'd0;
            vlmul_d = 3'd0;
          end else begin
            vl_d    = VLW'(cfg_vl);
            vill_d  = 1'b0;
            vsew_d  = vt_vsew;
            vlmul_d = vt_vlmul;
          end
        end else if (cnt_q <= VLW'(1)) begin
          // One element per cycle; vl of zero still costs one cycle.
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - VLW'(1);
        end
      end
      S_RESP: begin
        state_d  = S_WAIT;
        result_d = config_q ? 32'(vl_q) : 32'd0;
      end
      S_WAIT: begin
        // Bit 0 is already on o_rd in the first count cycle, so shift on the way into OUT.
        if (i_cnt_en) begin
          state_d  = S_OUT;
          result_d = {1'b0, result_q[31:1]};
        end
      end
      S_OUT: begin
        if (i_cnt_en) begin
          result_d = {1'b0, result_q[31:1]};
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_vpu_ready = (state_q == S_RESP);
  assign o_busy      = (state_q != S_IDLE);
  assign o_rd        = result_q[0];
  assign o_vl        = vl_q;
  assign o_vill      = vill_q;
  assign o_vsew      = vsew_q;
  assign o_vlmul     = vlmul_q;

endmodule

// File: tb/tb_serv_vpu_resp.sv
// Directed bench for serv_vpu_resp with a scoreboard of expected responses.
// Latency: checks ready timing per op against expected cycle counts.
// Backpressure: valid is held through the response to confirm a single ready pulse.
module tb_serv_vpu_resp;

  localparam int VLEN = 128;
  localparam int VLW  = $clog2(VLEN) + 1;

  logic           clk;
  logic           rst;
  logic           cnt_en;
  logic           init;
  logic           rs1;
  logic           rs2;
  logic           vpu_valid;
  logic           config_op;
  logic           vset_reg;
  logic [10:0]    zimm;
  logic           rs1_zero;
  logic           rd_zero;
  logic           vpu_ready;
  logic           rd;
  logic           busy;
  logic [VLW-1:0] vl;
  logic           vill;
  logic [2:0]     vsew;
  logic [2:0]     vlmul;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          lat;
    logic [31:0] vl;
    logic        vill;
    logic [2:0]  vsew;
    logic [2:0]  vlmul;
    logic [31:0] rd_word;
  } exp_t;

  exp_t sb[$];

  serv_vpu_resp #(.VLEN(VLEN)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_cnt_en    (cnt_en),
    .i_init      (init),
    .i_rs1       (rs1),
    .i_rs2       (rs2),
    .i_vpu_valid (vpu_valid),
    .i_config_op (config_op),
    .i_vset_reg  (vset_reg),
    .i_zimm      (zimm),
    .i_rs1_zero  (rs1_zero),
    .i_rd_zero   (rd_zero),
    .o_vpu_ready (vpu_ready),
    .o_rd        (rd),
    .o_busy      (busy),
    .o_vl        (vl),
    .o_vill      (vill),
    .o_vsew      (vsew),
    .o_vlmul     (vlmul)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(vpu_ready), 32'd0);
    chk({tag, "_rd"},    32'(rd),        32'd0);
    chk({tag, "_busy"},  32'(busy),      32'd0);
    chk({tag, "_vl"},    32'(vl),        32'd0);
    chk({tag, "_vill"},  32'(vill),      32'd1);
    chk({tag, "_vsew"},  32'(vsew),      32'd0);
    chk({tag, "_vlmul"}, 32'(vlmul),     32'd0);
  endtask

  // Stage one: shift both operands in LSB first; called at #1 after a rising edge.
  task automatic stage_one(input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < 32; i++) begin
      cnt_en = 1'b1;
      init   = 1'b1;
      rs1    = a[i];
      rs2    = b[i];
      @(posedge clk); #1;
    end
    cnt_en = 1'b0;
    init   = 1'b0;
    rs1    = 1'b0;
    rs2    = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic cfg, input logic [10:0] zi,
                        input logic vreg, input logic [31:0] a, input logic [31:0] b,
                        input logic r1z, input logic rdz, input exp_t e);
    exp_t got;
    int   cycles;
    logic seen;
    logic [31:0] word;
    sb.push_back(e);
    config_op = cfg;
    zimm      = zi;
    vset_reg  = vreg;
    rs1_zero  = r1z;
    rd_zero   = rdz;
    stage_one(a, b);
    vpu_valid = 1'b1;
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < 300) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      seen = vpu_ready;
    end
    got = sb.pop_front();
    chk({tag, "_ready_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(cycles), 32'(got.lat));
    chk({tag, "_vl"},    32'(vl),    got.vl);
    chk({tag, "_vill"},  32'(vill),  32'(got.vill));
    chk({tag, "_vsew"},  32'(vsew),  32'(got.vsew));
    chk({tag, "_vlmul"}, 32'(vlmul), 32'(got.vlmul));
    // Valid stays high through WAIT; ready must not repeat.
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_single_pulse"}, 32'(vpu_ready), 32'd0);
    chk({tag, "_busy_wait"}, 32'(busy), 32'd1);
    @(posedge clk); #1;
    vpu_valid = 1'b0;
    word = '0;
    for (int k = 0; k < 32; k++) begin
      cnt_en = 1'b1;
      @(negedge clk);
      word[k] = rd;
      @(posedge clk); #1;
    end
    cnt_en = 1'b0;
    chk({tag, "_rd_word"}, word, got.rd_word);
    @(posedge clk); #1;
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic seen;
    rst       = 1'b1;
    cnt_en    = 1'b0;
    init      = 1'b0;
    rs1       = 1'b0;
    rs2       = 1'b0;
    vpu_valid = 1'b0;
    config_op = 1'b0;
    vset_reg  = 1'b0;
    zimm      = '0;
    rs1_zero  = 1'b0;
    rd_zero   = 1'b0;
    #1;
    chk_reset_outputs("rst_async");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    chk_reset_outputs("rst_release");

    // SEW32 LMUL1: VLMAX 4, AVL 10 clamps to 4.
    run_op("vsetvli_e32", 1'b1, 11'h010, 1'b0, 32'd10, 32'd0, 1'b0, 1'b0,
           '{lat: 2, vl: 32'd4, vill: 1'b0, vsew: 3'd2, vlmul: 3'd0, rd_word: 32'd4});
    // Arithmetic with vl 4: four element cycles plus response.
    run_op("arith_vl4", 1'b0, 11'h000, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0,
           '{lat: 5, vl: 32'd4, vill: 1'b0, vsew: 3'd2, vlmul: 3'd0, rd_word: 32'd0});
    // Large AVL with upper bits set must clamp on a full 32-bit compare.
    run_op("vsetvli_bigavl", 1'b1, 11'h010, 1'b0, 32'hFFFF_0002, 32'd0, 1'b0, 1'b0,
           '{lat: 2, vl: 32'd4, vill: 1'b0, vsew: 3'd2, vlmul: 3'd0, rd_word: 32'd4});
    // SEW8 LMUL8: VLMAX 128.
    run_op("vsetvli_e8m8", 1'b1, 11'h003, 1'b0, 32'd100, 32'd0, 1'b0, 1'b0,
           '{lat: 2, vl: 32'd100, vill: 1'b0, vsew: 3'd0, vlmul: 3'd3, rd_word: 32'd100});
    run_op("vsetvli_x0_rd", 1'b1, 11'h003, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0,
           '{lat: 2, vl: 32'd128, vill: 1'b0, vsew: 3'd0, vlmul: 3'd3, rd_word: 32'd128});
    run_op("vsetvli_x0_x0", 1'b1, 11'h003, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1,
           '{lat: 2, vl: 32'd128, vill: 1'b0, vsew: 3'd0, vlmul: 3'd3, rd_word: 32'd128});
    // vsew 3 is illegal.
    run_op("vsetvli_vill", 1'b1, 11'h018, 1'b0, 32'd10, 32'd0, 1'b0, 1'b0,
           '{lat: 2, vl: 32'd0, vill: 1'b1, vsew: 3'd0, vlmul: 3'd0, rd_word: 32'd0});
    run_op("arith_vl0", 1'b0, 11'h000, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0,
           '{lat: 2, vl: 32'd0, vill: 1'b1, vsew: 3'd0, vlmul: 3'd0, rd_word: 32'd0});
`ifdef SERV_VPU_VSETVL_EN
    run_op("vsetvl_rs2", 1'b1, 11'h000, 1'b1, 32'd3, 32'h0000_0010, 1'b0, 1'b0,
           '{lat: 2, vl: 32'd3, vill: 1'b0, vsew: 3'd2, vlmul: 3'd0, rd_word: 32'd3});
    run_op("vsetvl_rs2_vill", 1'b1, 11'h010, 1'b1, 32'd3, 32'h0000_0800, 1'b0, 1'b0,
           '{lat: 2, vl: 32'd0, vill: 1'b1, vsew: 3'd0, vlmul: 3'd0, rd_word: 32'd0});
`endif

    // Reset in the middle of a long arithmetic op: immediate reset values, no ready afterwards.
    run_op("vsetvli_pre_rst", 1'b1, 11'h003, 1'b0, 32'd100, 32'd0, 1'b0, 1'b0,
           '{lat: 2, vl: 32'd100, vill: 1'b0, vsew: 3'd0, vlmul: 3'd3, rd_word: 32'd100});
    config_op = 1'b0;
    vpu_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mid_exec_busy", 32'(busy), 32'd1);
    rst       = 1'b1;
    vpu_valid = 1'b0;
    #1;
    chk_reset_outputs("rst_mid_exec");
    @(posedge clk); #1;
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (vpu_ready) seen = 1'b1;
    end
    chk("rst_no_ready", 32'(seen), 32'd0);
    chk("rst_still_idle", 32'(busy), 32'd0);
    chk("rst_sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
